// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline definitions: default payload width and the field layout
// of the widest payload carried through the skid stages.
package pipe_skid_reg_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  localparam int PC_OFF         = 0;
  localparam int PC_W           = 32;
  localparam int INSTR_OFF      = 32;
  localparam int INSTR_W        = 32;
  localparam int IMM32_OFF      = 64;
  localparam int IMM32_W        = 32;
  localparam int DM_RD_OFF      = 96;
  localparam int DM_RD_W        = 32;
  localparam int ALU_RESULT_OFF = 128;
  localparam int ALU_RESULT_W   = 32;
  localparam int B_JUDGE_OFF    = 160;
  localparam int B_JUDGE_W      = 1;
  localparam int PAYLOAD_W      = B_JUDGE_OFF + B_JUDGE_W;

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating event counter: +1 per enabled cycle, sticks at all-ones.
// Latency: count visible the edge after the event; no backpressure.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: registered valid/ready/data on both sides.
// Latency 1 cycle; in_ready drops only once the skid entry is occupied.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              main_valid;
  logic              skid_valid;
  logic              in_ready_q;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = main_valid & out_ready;

  // in_ready_q mirrors !skid_valid as its own flop so in_ready has no logic ahead of it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (out_fire && skid_valid) begin
      main_data  <= skid_data;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (in_fire && (!main_valid || out_fire)) begin
      main_data  <= in_data;
      main_valid <= 1'b1;
    end else if (in_fire) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
      in_ready_q <= 1'b0;
    end else if (out_fire) begin
      main_valid <= 1'b0;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign count     = {1'b0, main_valid} + {1'b0, skid_valid};

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (main_valid & ~out_ready),
    .cnt   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (~main_valid & out_ready),
    .cnt   (bubble_cnt)
  );

endmodule
